// File: rtl/dds_pkg.sv
// Shared constants, waveform encodings and the quarter-wave table generator
// for the DDS waveform generator.
package dds_pkg;

  localparam int ACC_W_DEF = 20;
  localparam int FW_W_DEF  = 16;

  localparam logic [9:0] MID = 10'd512;

  typedef enum logic [1:0] {
    SINE   = 2'b00,
    SQUARE = 2'b01,
    TRI    = 2'b10,
    SAW    = 2'b11
  } wave_e;

  // Elaboration-time only: round(511*sin(pi/2*(k+0.5)/256)) by Taylor series,
  // so the table needs no real-valued system functions in hardware.
  function automatic logic [8:0] qrom_entry(input int k);
    real x;
    real term;
    real s;
    x    = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / 256.0;
    term = x;
    s    = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return 9'($rtoi(511.0 * s + 0.5));
  endfunction

endpackage

// File: rtl/sine_qrom.sv
// 256x9 quarter-wave sine table with registered read; the read register
// holds its value while rd_en is low.
module sine_qrom
  import dds_pkg::*;
(
  input  logic       clk,
  input  logic       rd_en,
  input  logic [7:0] addr,
  output logic [8:0] amp
);

  logic [8:0] tbl [256];

  for (genvar k = 0; k < 256; k++) begin : g_rom
    localparam logic [8:0] ENTRY = qrom_entry(k);
    assign tbl[k] = ENTRY;
  end

  always_ff @(posedge clk) begin
    if (rd_en) amp <= tbl[addr];
  end

endmodule

// File: rtl/dds_wave_gen.sv
// Direct digital synthesis waveform generator: phase accumulator stepped on
// accepted ticks, two-stage pipeline producing a 10-bit offset-binary sample.
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int FW_W  = FW_W_DEF
) (
  input  logic            sysclk,
  input  logic            rst,
  input  logic            en,
  input  logic            tick,
  input  logic [FW_W-1:0] freq_word,
  input  logic [1:0]      wave_sel,
  input  logic            phase_clr,
  output logic [9:0]      data_out,
  output logic            data_valid
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] fw_ext;
  logic [9:0]       phase;
  logic             accept;

  logic       vld_p1;
  logic [9:0] p_p1;
  logic [7:0] addr_p1;
  logic       neg_p1;
  wave_e      mode_p1;

  logic       vld_p2;
  logic       neg_p2;
  wave_e      mode_p2;
  logic [9:0] wave_p2;
  logic [8:0] rom_amp;

  function automatic logic [9:0] shape(input logic [9:0] p, input wave_e mode);
    logic [9:0] ramp;
    ramp = {p[8:0], 1'b0};
    case (mode)
      SQUARE:  shape = p[9] ? 10'd0 : 10'd1023;
      TRI:     shape = p[9] ? ~ramp : ramp;
      SAW:     shape = p;
      default: shape = MID;
    endcase
  endfunction

  function automatic logic [9:0] sine_level(input logic neg, input logic [8:0] a);
    sine_level = neg ? (MID - {1'b0, a}) : (MID + {1'b0, a});
  endfunction

  assign fw_ext = {{(ACC_W - FW_W){1'b0}}, freq_word};
  assign phase  = acc[ACC_W-1 -: 10];
  assign accept = tick & en & ~phase_clr;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      acc    <= '0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
      if (phase_clr)   acc <= '0;
      else if (accept) acc <= acc + fw_ext;
    end
  end

  // Stage 1: capture phase, quarter-wave address, quadrant sign and mode
  always_ff @(posedge sysclk) begin
    if (accept) begin
      p_p1    <= phase;
      addr_p1 <= phase[8] ? ~phase[7:0] : phase[7:0];
      neg_p1  <= phase[9];
      mode_p1 <= wave_e'(wave_sel);
    end
  end

  // Stage 2: table read and non-sine shapes; forcing a non-sine mode on reset
  // makes data_out sit at mid-scale regardless of the stale table register
  sine_qrom u_qrom (
    .clk   (sysclk),
    .rd_en (vld_p1),
    .addr  (addr_p1),
    .amp   (rom_amp)
  );

  always_ff @(posedge sysclk) begin
    if (rst) begin
      mode_p2 <= SAW;
      wave_p2 <= MID;
      neg_p2  <= 1'b0;
    end else if (vld_p1) begin
      mode_p2 <= mode_p1;
      neg_p2  <= neg_p1;
      wave_p2 <= shape(p_p1, mode_p1);
    end
  end

  assign data_out   = (mode_p2 == SINE) ? sine_level(neg_p2, rom_amp) : wave_p2;
  assign data_valid = vld_p2;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen: the driver pushes expected samples from a
// phase/waveform reference model, a negedge monitor pops and compares them.
module tb_dds_wave_gen;

  localparam int ACC_W = 20;
  localparam int FW_W  = 16;
  localparam int MASK  = (1 << ACC_W) - 1;

  logic            sysclk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            tick = 1'b0;
  logic [FW_W-1:0] freq_word = '0;
  logic [1:0]      wave_sel = 2'b00;
  logic            phase_clr = 1'b0;
  logic [9:0]      data_out;
  logic            data_valid;

  dds_wave_gen #(.ACC_W(ACC_W), .FW_W(FW_W)) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .en         (en),
    .tick       (tick),
    .freq_word  (freq_word),
    .wave_sel   (wave_sel),
    .phase_clr  (phase_clr),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  always #10 sysclk = ~sysclk;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t sb[$];
  int   obs[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   m_acc = 0;

  always @(posedge sysclk) cyc <= cyc + 1;

  function automatic int rom_ref(input int k);
    real x;
    x = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / 256.0;
    return $rtoi(511.0 * $sin(x) + 0.5);
  endfunction

  // Sample value straight from the waveform definitions in plain arithmetic
  function automatic int ref_sample(input int p, input int sel);
    int q, i, a, t;
    case (sel)
      0: begin
        q = p / 256;
        i = p % 256;
        a = rom_ref((q % 2 == 1) ? 255 - i : i);
        return (q < 2) ? 512 + a : 512 - a;
      end
      1: return (p < 512) ? 1023 : 0;
      2: begin
        t = (p % 512) * 2;
        return (p < 512) ? t : 1023 - t;
      end
      default: return p;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge sysclk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_strobe: no data_valid for sample due at cycle %0d, now %0d", sb[0].due, cyc);
      void'(sb.pop_front());
    end
    if (data_valid === 1'b1) begin
      obs.push_back(int'(data_out));
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: data_valid with data_out %0d, none expected (cycle %0d)", data_out, cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (int'(data_out) != e.val || e.due != cyc) begin
          failures++;
          $display("FAIL sample: got %0d at cycle %0d, expected %0d at cycle %0d", data_out, cyc, e.val, e.due);
        end
      end
    end
  end

  task automatic step(input bit t, input bit e, input bit c, input bit r);
    exp_t keep[$];
    tick = t;
    en = e;
    phase_clr = c;
    rst = r;
    if (r) begin
      foreach (sb[j]) if (sb[j].due <= cyc) keep.push_back(sb[j]);
      sb = keep;
      m_acc = 0;
    end else if (c) begin
      m_acc = 0;
    end else if (t && e) begin
      sb.push_back('{ref_sample(m_acc >> (ACC_W - 10), int'(wave_sel)), cyc + 2});
      m_acc = (m_acc + int'(freq_word)) & MASK;
    end
    @(posedge sysclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int bad, mx, mn;
    @(posedge sysclk);
    #1;
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_data_out", int'(data_out), 512);
    check("reset_data_valid", int'(data_valid), 0);

    // Sawtooth ramp with wrap
    wave_sel = 2'b11;
    freq_word = 16'h0400;
    obs.delete();
    for (int j = 0; j < 1025; j++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(4);
    check("saw_count", obs.size(), 1025);
    if (obs.size() == 1025) begin
      check("saw_top", obs[1023], 1023);
      check("saw_wrap", obs[1024], 0);
    end

    // Square wave, 16 high then 16 low
    step(1'b0, 1'b1, 1'b1, 1'b0);
    wave_sel = 2'b01;
    freq_word = 16'h8000;
    obs.delete();
    for (int j = 0; j < 64; j++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(1);
    end
    idle(4);
    check("square_count", obs.size(), 64);
    if (obs.size() == 64) begin
      check("square_last_high", obs[15], 1023);
      check("square_first_low", obs[16], 0);
    end

    // Sine over one full period
    step(1'b0, 1'b1, 1'b1, 1'b0);
    wave_sel = 2'b00;
    freq_word = 16'h0400;
    obs.delete();
    for (int j = 0; j < 1024; j++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(1);
    end
    idle(4);
    check("sine_count", obs.size(), 1024);
    if (obs.size() == 1024) begin
      bad = 0;
      mx = 0;
      mn = 1024;
      for (int j = 0; j < 1024; j++) begin
        if (j < 512 && obs[j] + obs[j + 512] != 1024) bad++;
        if (obs[j] > mx) mx = obs[j];
        if (obs[j] < mn) mn = obs[j];
      end
      check("sine_symmetry_errors", bad, 0);
      check("sine_max", mx, 1023);
      check("sine_min", mn, 1);
      check("sine_p256", obs[256], 1023);
    end

    // Back-to-back ticks
    step(1'b0, 1'b1, 1'b1, 1'b0);
    wave_sel = 2'b11;
    obs.delete();
    for (int j = 0; j < 4; j++) step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("burst_count", obs.size(), 4);
    if (obs.size() == 4) check("burst_last", obs[3], 3);

    // Disabled ticks are ignored, sequence resumes without a gap
    obs.delete();
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("disabled_hold", int'(data_out), 3);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("resume_count", obs.size(), 1);
    if (obs.size() == 1) check("resume_value", obs[0], 4);

    // Reset one cycle after a tick flushes that sample
    obs.delete();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(1);
    check("flush_data_out", int'(data_out), 512);
    idle(3);
    check("flush_no_strobe", obs.size(), 0);
    wave_sel = 2'b11;
    for (int j = 0; j < 3; j++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("clr_count", obs.size(), 4);
    if (obs.size() == 4) check("clr_restart_p0", obs[3], 0);

    // Zero frequency word: constant output, still strobed
    wave_sel = 2'b10;
    freq_word = 16'h0000;
    obs.delete();
    for (int j = 0; j < 5; j++) step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("fw0_count", obs.size(), 5);

    // Randomized traffic
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 7) == 0) wave_sel = 2'($urandom);
      if ($urandom_range(0, 15) == 0) freq_word = 16'($urandom);
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 5) != 0),
           1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 150) == 0));
    end
    idle(6);
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
